// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial-subtract the divisor from
// the shifted partial remainder and keep the difference when it does not go negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_shift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  assign q_bit    = (rem_shift >= {1'b0, divisor});
  assign rem_next = q_bit ? WIDTH'(rem_shift - {1'b0, divisor}) : rem_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider: one quotient bit per clock, lo = quotient, hi = remainder.
// Define DIV_UNIT_SIGNED_EN for two's-complement operands (truncating division).
//
// state  | meaning
// IDLE   | waiting for start; operands captured when start is seen
// RUN    | one restoring step per cycle, cnt counts 0..WIDTH-1
// FINISH | done pulse; div_zero pulses too if the divisor was zero
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvs;
  logic             dz;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_final;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] res_hi;

`ifdef DIV_UNIT_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // Most-negative magnitude stays 1<<(WIDTH-1), which is correct as unsigned.
  assign op_a   = dividend[WIDTH-1] ? -dividend : dividend;
  assign op_b   = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign res_lo = neg_q ? -q_final  : q_final;
  assign res_hi = neg_r ? -rem_next : rem_next;
`else
  assign op_a   = dividend;
  assign op_b   = divisor;
  assign res_lo = q_final;
  assign res_hi = rem_next;
`endif

  // Dividend bits shift out of q's top while quotient bits shift into its bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_shift (({rem, q[WIDTH-1]})),
    .divisor   (dvs),
    .rem_next  (rem_next),
    .q_bit     (q_bit)
  );

  assign q_final = {q[WIDTH-2:0], q_bit};

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (divisor == '0) ? FINISH : RUN;
      RUN:     if (cnt == LAST) state_n = FINISH;
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      q     <= '0;
      dvs   <= '0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef DIV_UNIT_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            dz  <= (divisor == '0);
            cnt <= '0;
            rem <= '0;
            q   <= op_a;
            dvs <= op_b;
`ifdef DIV_UNIT_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
          end
        end
        RUN: begin
          rem <= rem_next;
          q   <= q_final;
          if (cnt == LAST) begin
            cnt <= '0;
            hi  <= res_hi;
            lo  <= res_lo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign div_zero = (state == FINISH) && dz;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  WIDTH  operand A (ALU A path); sampled with start.
REQ-006 divisor  input  WIDTH  operand B (ALU B path); sampled with start.
REQ-007 busy  output  1  high while a division is in progress.
REQ-008 done  output  1  one-cycle pulse when results are valid or div-by-zero is flagged.
REQ-009 div_zero  output  1  one-cycle pulse, coincident with done, when divisor was 0.
REQ-010 hi  output  WIDTH  remainder register.
REQ-011 lo  output  WIDTH  quotient register.

Function
REQ-012 FSM states: IDLE, RUN, FINISH; IDLE->RUN on start with divisor!=0; IDLE->FINISH on start with divisor==0; RUN->FINISH after WIDTH iterations; FINISH->IDLE unconditionally.
REQ-013 Operands shall be captured on the start cycle; later changes on dividend/divisor shall have no effect.
REQ-014 RUN shall perform one restoring-division step per cycle using a counter 0..WIDTH-1; counter wraps to 0 on leaving RUN.
REQ-015 Latency: start high at edge t (divisor!=0) -> done high during cycle t+WIDTH+1 (33 cycles for WIDTH=32).
REQ-016 Divisor zero: done and div_zero both pulse in the cycle after start; hi/lo unchanged.
REQ-017 hi/lo shall update only on entry to FINISH with a non-zero divisor and hold until the next successful division or reset.
REQ-018 busy high in RUN and FINISH, low in IDLE.
REQ-019 start while busy shall be ignored (no queuing, no effect on current operation).
REQ-020 done and div_zero shall never be high for more than one consecutive cycle.

Reset
REQ-021 reset high at any edge, including mid-RUN, shall force IDLE, counter 0, busy=0, done=0, div_zero=0, hi=0, lo=0; an in-flight division is discarded.
REQ-022 reset shall take priority over start in the same cycle.

Configuration
REQ-023 Macro DIV_UNIT_SIGNED_EN defined: operands are two's-complement; divide magnitudes; quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-024 DIV_UNIT_SIGNED_EN defined: most-negative / -1 shall give lo=most-negative (wrapped), hi=0, div_zero=0.
REQ-025 DIV_UNIT_SIGNED_EN undefined: operands and results are unsigned; no sign correction logic present; latency unchanged.

Structure
REQ-026 Package div_pkg shall hold the FSM state typedef (IDLE/RUN/FINISH), default WIDTH constant, and counter width constant ($clog2(WIDTH)).
REQ-027 One sub-module div_step shall implement a single combinational restoring step (shifted remainder in, divisor in -> new remainder, quotient bit out); div_unit instantiates one copy.

Verification
REQ-028 dividend=7, divisor=2, start 1 cycle -> done exactly 33 cycles later, lo=3, hi=1, div_zero=0, busy high for 33 cycles.
REQ-029 (signed) dividend=0xFFFFFFF9 (-7), divisor=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; (unsigned build) same stimulus -> lo=0x7FFFFFFC, hi=1.
REQ-030 dividend=100, divisor=0 -> next cycle done=1, div_zero=1; hi/lo retain previous values (e.g. 1/3 from prior op).
REQ-031 (signed) dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-032 Start 20/3, assert reset 10 cycles later for 1 cycle -> IDLE, hi=lo=0, no done pulse; new start 20/3 -> lo=6, hi=2 after 33 cycles.
REQ-033 Start 9/4, pulse start with 50/5 at cycle 5 -> only one done, lo=2, hi=1.
